// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_pkg
//  Description : Shared constants and helpers for the general-purpose
//                register bank and any other one-hot select logic.
//                c_DEF_ADDR_W : default address width (depth = 2**ADDR_W)
//                c_DEF_DATA_W : default data width per entry
//                c_DEF_N      : default depth
//                onehot()     : N-bit one-hot decode of an address
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

    localparam int c_DEF_ADDR_W = 4;
    localparam int c_DEF_DATA_W = 32;
    localparam int c_DEF_N      = 1 << c_DEF_ADDR_W;

    // Plain decode for the default depth; no enable gating is applied here.
    function automatic logic [c_DEF_N-1:0] onehot(input logic [c_DEF_ADDR_W-1:0] addr);
        logic [c_DEF_N-1:0] v_y;
        v_y       = '0;
        v_y[addr] = 1'b1;
        return v_y;
    endfunction

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_file_dec_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_dec_if
//  Description : Write/read bus of the register bank.
//                master (datapath) drives : we, waddr, wdata, raddr_a, raddr_b
//                slave  (reg bank) drives : rdata_a, rdata_b, wsel, vld
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_dec_if
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = c_DEF_ADDR_W,
    parameter int DATA_W = c_DEF_DATA_W
) ();

    localparam int N = 1 << ADDR_W;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr_a;
    logic [ADDR_W-1:0] raddr_b;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic [N-1:0]      wsel;
    logic [N-1:0]      vld;

    modport master (
        output we, waddr, wdata, raddr_a, raddr_b,
        input  rdata_a, rdata_b, wsel, vld
    );

    modport slave (
        input  we, waddr, wdata, raddr_a, raddr_b,
        output rdata_a, rdata_b, wsel, vld
    );

endinterface : reg_file_dec_if
`default_nettype wire

// File: rtl/reg_file_dec_decode_onehot.sv
`default_nettype none
// ============================================================================
//  Module      : decode_onehot
//  Description : Parametrised address-to-one-hot decoder with enable.
//                addr : address to decode
//                en   : when low, all outputs are low
//                y    : one-hot select, y[i] = en & (addr == i)
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_onehot
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = c_DEF_ADDR_W
) (
    input  wire logic [ADDR_W-1:0]      addr,
    input  wire logic                   en,
    output logic [(1 << ADDR_W)-1:0]    y
);

    localparam int c_N = 1 << ADDR_W;

    // Pure AND of enable with a per-entry comparator; downstream logic
    // only samples y on clk, so transient glitches are harmless.
    generate
        for (genvar i = 0; i < c_N; i++) begin : g_dec
            assign y[i] = en & (addr == ADDR_W'(i));
        end
    endgenerate

endmodule : decode_onehot
`default_nettype wire

// File: rtl/reg_file_dec.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_dec
//  Description : 2**ADDR_W x DATA_W register bank with one-hot write decode,
//                two registered read ports, optional same-edge bypass and
//                optional hardwired-zero entry 0.
//                clk  : rising-edge clock
//                rst  : synchronous active-high reset
//                bus  : slave side of reg_file_dec_if
//                       (we/waddr/wdata, raddr_a/b in; rdata_a/b, wsel, vld out)
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_dec
    import reg_file_pkg::*;
#(
    parameter int ADDR_W   = c_DEF_ADDR_W,
    parameter int DATA_W   = c_DEF_DATA_W,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    reg_file_dec_if.slave   bus
);

    localparam int c_N = 1 << ADDR_W;

    logic              w_wr_en;
    logic [c_N-1:0]    w_dec;
    logic [c_N-1:0]    w_wsel;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    logic [DATA_W-1:0] r_mem [c_N];
    logic [c_N-1:0]    r_vld;
    logic [DATA_W-1:0] r_rdata_a;
    logic [DATA_W-1:0] r_rdata_b;

    // Reset suppresses the strobe so a write coinciding with reset is dropped.
    assign w_wr_en = bus.we & ~rst;

    decode_onehot #(
        .ADDR_W (ADDR_W)
    ) u_decode (
        .addr (bus.waddr),
        .en   (w_wr_en),
        .y    (w_dec)
    );

    generate
        if (ZERO_REG) begin : g_zero_reg
            assign w_wsel = {w_dec[c_N-1:1], 1'b0};
        end else begin : g_no_zero_reg
            assign w_wsel = w_dec;
        end
    endgenerate

    // Next read data per port: forwarded write data when the port reads the
    // entry being written this edge, forced zero for the hardwired entry.
    always_comb begin
        w_rd_a = r_mem[bus.raddr_a];
        if (BYPASS && w_wsel[bus.raddr_a]) begin
            w_rd_a = bus.wdata;
        end
        if (ZERO_REG && (bus.raddr_a == '0)) begin
            w_rd_a = '0;
        end
    end

    always_comb begin
        w_rd_b = r_mem[bus.raddr_b];
        if (BYPASS && w_wsel[bus.raddr_b]) begin
            w_rd_b = bus.wdata;
        end
        if (ZERO_REG && (bus.raddr_b == '0)) begin
            w_rd_b = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_N; i++) begin
                r_mem[i] <= '0;
            end
            r_vld     <= '0;
            r_rdata_a <= '0;
            r_rdata_b <= '0;
        end else begin
            for (int i = 0; i < c_N; i++) begin
                if (w_wsel[i]) begin
                    r_mem[i] <= bus.wdata;
                    r_vld[i] <= 1'b1;
                end
            end
            r_rdata_a <= w_rd_a;
            r_rdata_b <= w_rd_b;
        end
    end

    assign bus.wsel    = w_wsel;
    assign bus.vld     = r_vld;
    assign bus.rdata_a = r_rdata_a;
    assign bus.rdata_b = r_rdata_b;

endmodule : reg_file_dec
`default_nettype wire
